// File: rtl/mem_pkg.sv
// Shared constants and state type for the backing-memory line responder.
package mem_pkg;

  localparam int LINE_BITS        = 512;
  localparam int LINE_OFFSET_BITS = 6;
  localparam int LINE_ADDR_BITS   = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/line_ram.sv
// Single-port synchronous line array: write-first registered read, no reset.
module line_ram #(
  parameter  int WIDTH = 512,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // A write also drives rdata so the response can echo the written line.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_line_responder.sv
// Backing-memory responder for cache line fills/writebacks with fixed latency.
// Define MEM_LINE_ERR_EN to add o_err and out-of-range access suppression.
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int LINE_BITS   = mem_pkg::LINE_BITS,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [LINE_ADDR_BITS-1:0] i_req_addr,
  input  logic [LINE_BITS-1:0]      i_req_wdata,
  output logic [LINE_BITS-1:0]      o_memory_line,
  output logic                      o_memory_response,
`ifdef MEM_LINE_ERR_EN
  output logic                      o_err,
`endif
  output logic                      o_busy
);

  // state | meaning
  // IDLE  | ready for a request
  // WAIT  | counting down the access latency; access happens when count hits 0
  // RESP  | response strobe cycle, line valid on o_memory_line

  localparam int        IDX_W    = $clog2(DEPTH_LINES);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_e                    state_q, state_d;
  logic [7:0]                cnt_q;
  logic                      we_q;
  logic [LINE_ADDR_BITS-1:0] addr_q;
  logic [LINE_BITS-1:0]      wdata_q;
  logic                      line_clear_q;
  logic [LINE_BITS-1:0]      ram_rdata;
  logic [IDX_W-1:0]          ram_idx;
  logic                      accept;
  logic                      access;
  logic                      out_of_range;

  assign accept  = i_req_valid & o_req_ready;
  assign access  = (state_q == WAIT) && (cnt_q == '0);
  // Power-of-two modulo: upper address bits wrap onto the index.
  assign ram_idx = IDX_W'(addr_q % DEPTH_LINES);

`ifdef MEM_LINE_ERR_EN
  assign out_of_range = |(addr_q >> IDX_W);
`else
  assign out_of_range = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_clear_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= CNT_LOAD;
        we_q    <= i_req_we;
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      // Cleared line masks the uninitialised RAM output after reset and
      // forces zeros for a rejected access.
      if (access) begin
        line_clear_q <= out_of_range;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready       = (state_q == IDLE);
    o_busy            = (state_q != IDLE);
    o_memory_response = (state_q == RESP) && !rst;
`ifdef MEM_LINE_ERR_EN
    o_err             = (state_q == RESP) && line_clear_q && !rst;
`endif
  end

  assign o_memory_line = line_clear_q ? '0 : ram_rdata;

  line_ram #(
    .WIDTH (LINE_BITS),
    .DEPTH (DEPTH_LINES)
  ) u_line_ram (
    .clk   (clk),
    .en    (access && !rst && !out_of_range),
    .we    (we_q),
    .addr  (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench: two responders (latency 4 and latency 1) against an array model.
module tb_mem_line_responder;

  localparam int LB = 512;

  typedef struct {
    int             k;
    int             cyc;
    logic [LB-1:0]  line;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  logic [25:0]   req_addr  [2];
  logic [LB-1:0] req_wdata [2];
  logic [LB-1:0] mem_line  [2];
  logic          resp      [2];
  logic          busy      [2];

  int            cyc;
  int            n_cmp;
  int            n_bad;
  int            free_at [2];
  logic [LB-1:0] model [2][256];
  exp_t          sbq [$];

  mem_line_responder #(.LINE_BITS(LB), .DEPTH_LINES(256), .LATENCY(4)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .i_req_valid       (req_valid[0]),
    .o_req_ready       (req_ready[0]),
    .i_req_we          (req_we[0]),
    .i_req_addr        (req_addr[0]),
    .i_req_wdata       (req_wdata[0]),
    .o_memory_line     (mem_line[0]),
    .o_memory_response (resp[0]),
    .o_busy            (busy[0])
  );

  mem_line_responder #(.LINE_BITS(LB), .DEPTH_LINES(256), .LATENCY(1)) u_dut1 (
    .clk               (clk),
    .rst               (rst),
    .i_req_valid       (req_valid[1]),
    .o_req_ready       (req_ready[1]),
    .i_req_we          (req_we[1]),
    .i_req_addr        (req_addr[1]),
    .i_req_wdata       (req_wdata[1]),
    .o_memory_line     (mem_line[1]),
    .o_memory_response (resp[1]),
    .o_busy            (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] d;
    for (int i = 0; i < LB / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(input string nm, input int k, input logic [LB-1:0] act,
                     input logic [LB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got %h want %h", nm, k, cyc, act, exp);
    end
  endtask

  // Monitor: ready/busy follow the one-outstanding issue model; every strobe
  // must match the oldest expected response in both data and cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        chk("ready", k, LB'(req_ready[k]), LB'(cyc >= free_at[k]));
        chk("busy", k, LB'(busy[k]), LB'(cyc < free_at[k]));
      end
      if (resp[k]) begin
        if (sbq.size() == 0 || sbq[0].k != k) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe dut%0d cyc %0d: got strobe want none", k, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("strobe_cycle", k, LB'(cyc), LB'(e.cyc));
          chk("line", k, mem_line[k], e.line);
        end
      end
    end
  end

  task automatic scramble(input int k);
    req_we[k]    = 1'($urandom);
    req_addr[k]  = 26'($urandom);
    req_wdata[k] = rand_line();
  endtask

  // Called #1 after a rising edge. Holds valid (with junk payload) until the
  // modelled ready cycle, presents the real request there, then drops valid.
  task automatic issue(input int k, input bit we, input logic [25:0] addr,
                       input logic [LB-1:0] data, input bit push);
    int   n;
    exp_t e;
    n = (cyc > free_at[k]) ? cyc : free_at[k];
    req_valid[k] = 1'b1;
    while (cyc < n) begin
      scramble(k);
      @(posedge clk);
      #1;
    end
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = data;
    @(posedge clk);
    free_at[k] = n + lat(k) + 2;
    #1;
    req_valid[k] = 1'b0;
    scramble(k);
    if (push) begin
      e.k   = k;
      e.cyc = n + lat(k) + 1;
      if (we) begin
        model[k][addr[7:0]] = data;
        e.line = data;
      end else begin
        e.line = model[k][addr[7:0]];
      end
      sbq.push_back(e);
    end
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    repeat (ncyc) @(posedge clk);
    free_at[0] = 0;
    free_at[1] = 0;
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int ncyc);
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [LB-1:0] a5;
    logic [LB-1:0] ones;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    free_at[0] = 0;
    free_at[1] = 0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      scramble(k);
      for (int i = 0; i < 256; i++) model[k][i] = '0;
    end
    for (int i = 0; i < LB / 8; i++) a5[i*8 +: 8] = 8'hA5;
    ones = '1;

    do_reset(2);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", k, LB'(req_ready[k]), LB'(1));
      chk("rst_resp", k, LB'(resp[k]), LB'(0));
      chk("rst_busy", k, LB'(busy[k]), LB'(0));
      chk("rst_line", k, mem_line[k], '0);
    end

    issue(0, 1'b1, 26'h10, a5, 1'b1);
    issue(0, 1'b0, 26'h10, '0, 1'b1);
    issue(0, 1'b1, 26'h105, LB'(32'h1234), 1'b1);
    issue(0, 1'b0, 26'h005, '0, 1'b1);
    // Second request held with junk while the first is in flight.
    issue(0, 1'b0, 26'h10, '0, 1'b1);
    issue(0, 1'b0, 26'h33, '0, 1'b1);
    idle(8);

    // Write aborted by reset two cycles after acceptance: never lands.
    issue(0, 1'b1, 26'h20, ones, 1'b0);
    idle(1);
    do_reset(2);
    chk("abort_busy", 0, LB'(busy[0]), LB'(0));
    chk("abort_line", 0, mem_line[0], '0);
    issue(0, 1'b0, 26'h20, '0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [25:0] a;
      a = (i % 3 == 0) ? 26'($urandom) : 26'($urandom_range(0, 7));
      issue(0, 1'($urandom), a, rand_line(), 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 8));
    end
    idle(8);

    issue(1, 1'b0, 26'h1, '0, 1'b1);
    issue(1, 1'b0, 26'h2, '0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      issue(1, 1'($urandom), 26'($urandom_range(0, 3)), rand_line(), 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end

    idle(10);
    chk("drain", 0, LB'(sbq.size()), LB'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
